// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC and the IF/ID register, fetches over a
// variable-latency req/ack port and applies hazard-unit stall/flush requests.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             PC_stall_i,
  input  logic             IFID_stall_i,
  input  logic             flush_i,
  input  logic [31:0]      branch_addr_i,
  output logic             imem_req_o,
  output logic [31:0]      imem_addr_o,
  input  logic             imem_ack_i,
  input  logic [31:0]      imem_data_i,
  output logic [31:0]      IFID_pc_o,
  output logic [31:0]      IFID_instr_o,
  output logic             IFID_valid_o,
  output logic             fetch_busy_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      ifid_pc_q, ifid_pc_d;
  logic [31:0]      ifid_instr_q, ifid_instr_d;
  logic             ifid_valid_q, ifid_valid_d;
  logic [31:0]      skid_q, skid_d;
  logic             redir_q, redir_d;
  logic [31:0]      target_q, target_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             fetch_req;
  logic             fetch_ack;
  logic             active;
  logic [31:0]      pc_inc;

  assign fetch_req    = (state_q == S_FETCH);
  assign fetch_ack    = fetch_req & imem_ack_i;
  assign active       = (state_q == S_FETCH) || (state_q == S_HOLD);
  // Only the word index is incremented, so pc[1:0] passes through untouched.
  assign pc_inc       = {pc_q[31:2] + 30'd1, pc_q[1:0]};

  assign imem_req_o   = fetch_req;
  assign imem_addr_o  = pc_q;
  assign fetch_busy_o = fetch_req & ~imem_ack_i;
  assign IFID_pc_o    = ifid_pc_q;
  assign IFID_instr_o = ifid_instr_q;
  assign IFID_valid_o = ifid_valid_q;
  assign stall_cnt_o  = cnt_q;

  // Next-state logic: flush > IF/ID stall > PC stall > normal fetch.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    skid_d       = skid_q;
    redir_d      = redir_q;
    target_d     = target_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (flush_i) begin
          ifid_pc_d    = 32'h0000_0000;
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
          skid_d       = 32'h0000_0000;
          if (fetch_ack) begin
            pc_d    = branch_addr_i;
            redir_d = 1'b0;
          end else begin
            // Keep the outstanding address stable; redirect once it is acked.
            target_d = branch_addr_i;
            redir_d  = 1'b1;
          end
        end else if (redir_q) begin
          if (!IFID_stall_i) begin
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
          end else begin
            ifid_valid_d = ifid_valid_q;
          end
          if (fetch_ack) begin
            pc_d    = target_q;
            redir_d = 1'b0;
          end else begin
            pc_d = pc_q;
          end
        end else if (IFID_stall_i) begin
          if (fetch_ack) begin
            skid_d  = imem_data_i;
            state_d = S_HOLD;
          end else begin
            state_d = S_FETCH;
          end
        end else if (PC_stall_i || !fetch_ack) begin
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
        end else begin
          ifid_pc_d    = pc_inc;
          ifid_instr_d = imem_data_i;
          ifid_valid_d = 1'b1;
          pc_d         = pc_inc;
        end
      end
      S_HOLD: begin
        if (flush_i) begin
          ifid_pc_d    = 32'h0000_0000;
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
          skid_d       = 32'h0000_0000;
          pc_d         = branch_addr_i;
          redir_d      = 1'b0;
          state_d      = S_FETCH;
        end else if (!IFID_stall_i) begin
          ifid_pc_d    = pc_inc;
          ifid_instr_d = skid_q;
          ifid_valid_d = 1'b1;
          pc_d         = pc_inc;
          state_d      = S_FETCH;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (active && (fetch_busy_o || IFID_stall_i) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and pipeline registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      ifid_pc_q    <= 32'h0000_0000;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      skid_q       <= 32'h0000_0000;
      redir_q      <= 1'b0;
      target_q     <= 32'h0000_0000;
      cnt_q        <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      skid_q       <= skid_d;
      redir_q      <= redir_d;
      target_q     <= target_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a program-order model predicts the
// stream of instructions entering ID; a monitor checks every IF/ID update.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, PC_stall_i, IFID_stall_i, flush_i;
  logic [31:0] branch_addr_i;
  logic        imem_req_o, imem_ack_i, IFID_valid_o, fetch_busy_o;
  logic [31:0] imem_addr_o, imem_data_i, IFID_pc_o, IFID_instr_o;
  logic [3:0]  stall_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;
  int n_entries = 0;
  int mem_lat = 0;
  logic mem_manual = 1'b0;
  logic mon_en = 1'b0;
  logic [31:0] exp_q[$];

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP), .CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .PC_stall_i(PC_stall_i),
    .IFID_stall_i(IFID_stall_i), .flush_i(flush_i), .branch_addr_i(branch_addr_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i),
    .imem_data_i(imem_data_i), .IFID_pc_o(IFID_pc_o), .IFID_instr_o(IFID_instr_o),
    .IFID_valid_o(IFID_valid_o), .fetch_busy_o(fetch_busy_o), .stall_cnt_o(stall_cnt_o)
  );

  initial forever #5 clk = ~clk;

  // Contents of instruction memory at a given address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected program order from a new start/redirect address (wraps mod 2^32).
  task automatic restart_stream(input logic [31:0] base);
    logic [31:0] a;
    a = base;
    exp_q.delete();
    for (int i = 0; i < 512; i++) begin
      exp_q.push_back(a);
      a = a + 32'd4;
    end
  endtask

  // Instruction memory: latency mem_lat wait cycles (<0 = random 0..3).
  initial begin : memory
    logic [31:0] req_addr;
    int wait_cnt, lat_cur;
    logic first;
    imem_ack_i = 1'b0; imem_data_i = 32'h0; first = 1'b1; wait_cnt = 0; lat_cur = 0;
    req_addr = 32'h0;
    forever begin
      @(negedge clk);
      if (!mem_manual) begin
        if (rst || !imem_req_o) begin
          imem_ack_i = 1'b0; wait_cnt = 0; first = 1'b1;
        end else begin
          if (first) begin
            req_addr = imem_addr_o;
            lat_cur  = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
            first    = 1'b0;
          end else begin
            chk("addr_stable", imem_addr_o, req_addr);
          end
          if (wait_cnt >= lat_cur) begin
            imem_ack_i = 1'b1; imem_data_i = memf(imem_addr_o); wait_cnt = 0; first = 1'b1;
          end else begin
            imem_ack_i = 1'b0; imem_data_i = 32'hBAD0_BAD0; wait_cnt++;
          end
        end
      end
    end
  end

  // Monitor: checks every IF/ID update against the expected stream.
  initial begin : monitor
    logic [31:0] prev_pc, prev_instr, a;
    logic prev_valid;
    prev_pc = 32'h0; prev_instr = NOP; prev_valid = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (mon_en && !rst) begin
        if (flush_i) begin
          chk("flush_pc", IFID_pc_o, 32'h0);
          chk("flush_instr", IFID_instr_o, NOP);
          chk("flush_valid", {31'd0, IFID_valid_o}, 32'd0);
        end else if (IFID_stall_i) begin
          chk("hold_pc", IFID_pc_o, prev_pc);
          chk("hold_instr", IFID_instr_o, prev_instr);
          chk("hold_valid", {31'd0, IFID_valid_o}, {31'd0, prev_valid});
        end else if (IFID_valid_o) begin
          if (exp_q.size() == 0) begin
            chk("stream_underflow", IFID_pc_o, 32'hFFFF_FFFF);
          end else begin
            a = exp_q.pop_front();
            chk("entry_pc", IFID_pc_o, a + 32'd4);
            chk("entry_instr", IFID_instr_o, memf(a));
            n_entries++;
          end
        end else begin
          chk("bubble_pc", IFID_pc_o, prev_pc);
          chk("bubble_instr", IFID_instr_o, NOP);
        end
      end
      prev_pc = IFID_pc_o; prev_instr = IFID_instr_o; prev_valid = IFID_valid_o;
    end
  end

  task automatic do_reset();
    mon_en = 1'b0;
    @(negedge clk);
    rst = 1'b1; start_i = 1'b0; PC_stall_i = 1'b0; IFID_stall_i = 1'b0; flush_i = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start_i = 1'b1; restart_stream(32'h0000_0000); mon_en = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_addr(input logic [31:0] a);
    int k;
    k = 0;
    @(negedge clk);
    while (!(imem_req_o && imem_addr_o == a) && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) chk("wait_addr_timeout", imem_addr_o, a);
  endtask

  task automatic wait_entries(input int n);
    int target, k;
    target = n_entries + n;
    k = 0;
    while (n_entries < target && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (n_entries < target) chk("entries_timeout", n_entries, target);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_req"}, {31'd0, imem_req_o}, 32'd0);
    chk({nm, "_addr"}, imem_addr_o, 32'h0);
    chk({nm, "_pc"}, IFID_pc_o, 32'h0);
    chk({nm, "_instr"}, IFID_instr_o, NOP);
    chk({nm, "_valid"}, {31'd0, IFID_valid_o}, 32'd0);
    chk({nm, "_busy"}, {31'd0, fetch_busy_o}, 32'd0);
    chk({nm, "_cnt"}, {28'd0, stall_cnt_o}, 32'd0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    rst = 1'b1; start_i = 1'b0; PC_stall_i = 1'b0; IFID_stall_i = 1'b0;
    flush_i = 1'b0; branch_addr_i = 32'h0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;

    // Stray ack while idle must be ignored.
    mem_manual = 1'b1; imem_ack_i = 1'b1; imem_data_i = 32'hDEAD_BEEF;
    @(negedge clk); #1;
    chk("idle_ack_valid", {31'd0, IFID_valid_o}, 32'd0);
    chk("idle_ack_cnt", {28'd0, stall_cnt_o}, 32'd0);
    imem_ack_i = 1'b0; mem_manual = 1'b0;

    // 1: zero-wait memory, back-to-back issue.
    mem_lat = 0;
    do_start();
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); #1;
      chk("zw_valid", {31'd0, IFID_valid_o}, 32'd1);
      chk("zw_pc", IFID_pc_o, 32'(i * 4));
    end
    chk("zw_cnt", {28'd0, stall_cnt_o}, 32'd0);

    // 2: three-cycle memory latency.
    do_reset();
    mem_lat = 2;
    do_start();
    #1;
    chk("lat_busy", {31'd0, fetch_busy_o}, 32'd1);
    @(negedge clk); #1;
    chk("lat_addr", imem_addr_o, 32'h0);
    chk("lat_valid0", {31'd0, IFID_valid_o}, 32'd0);
    @(negedge clk); #1;
    chk("lat_valid1", {31'd0, IFID_valid_o}, 32'd0);
    @(negedge clk); #1;
    chk("lat_first", {31'd0, IFID_valid_o}, 32'd1);
    chk("lat_cnt", {28'd0, stall_cnt_o}, 32'd2);
    wait_entries(3);

    // 3: combined PC/IF-ID stall while the word at 0x8 is acked.
    do_reset();
    mem_lat = 0;
    do_start();
    wait_addr(32'h8);
    PC_stall_i = 1'b1; IFID_stall_i = 1'b1;
    @(negedge clk);
    PC_stall_i = 1'b0; IFID_stall_i = 1'b0;
    #1 chk("skid_hold_pc", IFID_pc_o, 32'h8);
    @(negedge clk); #1;
    chk("skid_pc", IFID_pc_o, 32'hC);
    chk("skid_instr", IFID_instr_o, memf(32'h8));
    wait_entries(4);

    // 4: flush while the word at 0x10 is acked.
    do_reset();
    do_start();
    wait_addr(32'h10);
    flush_i = 1'b1; branch_addr_i = 32'h40; restart_stream(32'h40);
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    chk("flush_ack_addr", imem_addr_o, 32'h40);
    chk("flush_ack_valid", {31'd0, IFID_valid_o}, 32'd0);
    wait_entries(4);

    // 5: flush while the request to 0x20 is still waiting.
    do_reset();
    mem_lat = 2;
    do_start();
    wait_addr(32'h20);
    flush_i = 1'b1; branch_addr_i = 32'h80; restart_stream(32'h80);
    @(negedge clk);
    flush_i = 1'b0;
    #1 chk("pend_addr0", imem_addr_o, 32'h20);
    @(negedge clk); #1;
    chk("pend_addr1", imem_addr_o, 32'h20);
    chk("pend_ack", {31'd0, imem_ack_i}, 32'd1);
    @(negedge clk); #1;
    chk("pend_redirect", imem_addr_o, 32'h80);
    wait_entries(3);

    // 6a: reset in the middle of an outstanding request.
    do_reset();
    mem_lat = 3;
    do_start();
    @(negedge clk); #1;
    chk("midreq_busy", {31'd0, fetch_busy_o}, 32'd1);
    mon_en = 1'b0; rst = 1'b1;
    #1 chk_reset_vals("rst_midreq");
    @(negedge clk);
    rst = 1'b0;

    // 6b: reset in the middle of HOLD.
    mem_lat = 0;
    do_start();
    @(negedge clk);
    IFID_stall_i = 1'b1;
    @(negedge clk); #1;
    chk("hold_req", {31'd0, imem_req_o}, 32'd0);
    mon_en = 1'b0; #1 rst = 1'b1;
    #1 chk_reset_vals("rst_midhold");
    @(negedge clk);
    IFID_stall_i = 1'b0; rst = 1'b0;

    // PC wrap past 0xFFFF_FFFC with random latency.
    mem_lat = -1;
    do_start();
    @(negedge clk);
    flush_i = 1'b1; branch_addr_i = 32'hFFFF_FFF0; restart_stream(32'hFFFF_FFF0);
    @(negedge clk);
    flush_i = 1'b0;
    wait_entries(6);

    // Stall counter saturation.
    do_reset();
    mem_lat = 0;
    do_start();
    IFID_stall_i = 1'b1;
    repeat (20) @(negedge clk);
    IFID_stall_i = 1'b0;
    #1 chk("cnt_sat", {28'd0, stall_cnt_o}, 32'hF);
    repeat (5) @(negedge clk);
    #1 chk("cnt_sat_hold", {28'd0, stall_cnt_o}, 32'hF);

    // Random stalls, flushes and memory latency.
    do_reset();
    mem_lat = -1;
    do_start();
    begin
      int base_entries;
      base_entries = n_entries;
      for (int c = 0; c < 1500; c++) begin
        @(negedge clk);
        IFID_stall_i = ($urandom_range(0, 3) == 0);
        PC_stall_i   = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 11) == 0) begin
          flush_i = 1'b1;
          branch_addr_i = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
          restart_stream(branch_addr_i);
        end else begin
          flush_i = 1'b0;
        end
      end
      @(negedge clk);
      IFID_stall_i = 1'b0; PC_stall_i = 1'b0; flush_i = 1'b0;
      repeat (10) @(negedge clk);
      n_tests++;
      if (n_entries - base_entries < 100) begin
        n_fail++;
        $display("FAIL rand_progress: got %0d entries expected at least 100", n_entries - base_entries);
      end
    end
    mon_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
